// File: rtl/core_decode_pkg.sv
// Shared decode-stage definitions: RV64 opcodes, immediate-type codes and
// the encoding of the two-entry decode/execute skid buffer.
package core_decode_pkg;

  // Major opcodes (instruction bits [6:0]) recognised by the decode stage
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // Immediate format selector shared by the classifier and ImmediateDecoder
  typedef logic [2:0] imm_type_t;

  localparam imm_type_t IMM_I    = 3'b000;
  localparam imm_type_t IMM_S    = 3'b001;
  localparam imm_type_t IMM_B    = 3'b010;
  localparam imm_type_t IMM_U    = 3'b011;
  localparam imm_type_t IMM_J    = 3'b100;
  localparam imm_type_t IMM_NONE = 3'b111;

  // Occupancy of the skid buffer facing execute
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

endpackage : core_decode_pkg

// File: rtl/decode_stage_controller_imm_decoder.sv
// ImmediateDecoder: pure combinational extraction of the sign-extended
// immediate from instruction bits [31:7] for a given immediate format.
module ImmediateDecoder
  import core_decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:7]     inst_i,
  input  imm_type_t       imm_type_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  // Reassemble the scattered immediate bits into a 32-bit signed value
  always_comb begin
    // NOTE: default first so every path assigns imm32 and no latch is inferred;
    // unknown formats also yield 0 rather than X.
    imm32 = '0;
    case (imm_type_i)
      IMM_I: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                      inst_i[30:25], inst_i[11:8], 1'b0};
      IMM_U: imm32 = {inst_i[31:12], 12'b0};
      IMM_J: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                      inst_i[20], inst_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = {{(XLEN-32){imm32[31]}}, imm32};

endmodule : ImmediateDecoder

// File: rtl/decode_stage_controller.sv
// Decode stage sequencer: accepts fetched instructions, classifies the
// opcode, decodes the immediate and queues results in a two-entry skid
// buffer towards execute. Also tracks downstream stall cycles.
module decode_stage_controller
  import core_decode_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  // Fetch side
  input  logic                   fetchValid,
  output logic                   fetchReady,
  input  logic [31:0]            fetchInst,
  input  logic [XLEN-1:0]        fetchPc,
  // Branch flush
  input  logic                   flush,
  // Execute side
  output logic                   exValid,
  input  logic                   exReady,
  output logic [XLEN-1:0]        exPc,
  output logic [31:0]            exInst,
  output logic [2:0]             exImmType,
  output logic [XLEN-1:0]        exImm,
  output logic [4:0]             exRs1,
  output logic [4:0]             exRs2,
  output logic [4:0]             exRd,
  output logic                   exIllegal,
  output logic [STALL_CNT_W-1:0] stallCount
);

  // One decoded instruction as held in the buffer
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    imm_type_t       imm_type;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            illegal;
  } entry_t;

  buf_state_e             state_q, state_d;
  entry_t                 head_q, head_d;
  entry_t                 skid_q, skid_d;
  logic                   fetch_ready_q, fetch_ready_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  imm_type_t       cls_imm_type;
  logic            cls_illegal;
  logic [XLEN-1:0] dec_imm;
  entry_t          new_entry;

  logic accept;
  logic retire;

  // Handshakes; a flush suppresses any same-cycle accept
  assign exValid = (state_q != EMPTY);
  assign accept  = fetchValid & fetch_ready_q & ~flush;
  assign retire  = exValid & exReady;

  // Classify the incoming opcode into an immediate format
  always_comb begin
    cls_imm_type = IMM_NONE;
    cls_illegal  = 1'b0;
    case (fetchInst[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32,
      OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: cls_imm_type = IMM_I;
      OPC_STORE:                          cls_imm_type = IMM_S;
      OPC_BRANCH:                         cls_imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC:                 cls_imm_type = IMM_U;
      OPC_JAL:                            cls_imm_type = IMM_J;
      OPC_OP, OPC_OP_32:                  cls_imm_type = IMM_NONE;
      default: begin
        cls_imm_type = IMM_NONE;
        cls_illegal  = 1'b1;
      end
    endcase
  end

  ImmediateDecoder #(
    .XLEN(XLEN)
  ) u_imm_decoder (
    .inst_i    (fetchInst[31:7]),
    .imm_type_i(cls_imm_type),
    .imm_o     (dec_imm)
  );

  // Assemble the entry that an accept would write into the buffer
  always_comb begin
    new_entry          = '0;
    new_entry.pc       = fetchPc;
    new_entry.inst     = fetchInst;
    new_entry.imm_type = cls_imm_type;
    new_entry.imm      = (cls_imm_type == IMM_NONE) ? '0 : dec_imm;
    new_entry.rs1      = fetchInst[19:15];
    new_entry.rs2      = fetchInst[24:20];
    new_entry.rd       = fetchInst[11:7];
    new_entry.illegal  = cls_illegal;
  end

  // Buffer occupancy next-state and entry movement
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          head_d  = new_entry;
        end
      end
      ONE: begin
        if (accept && retire) begin
          head_d = new_entry;
        end else if (accept) begin
          state_d = TWO;
          skid_d  = new_entry;
        end else if (retire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (retire) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  // Registered fetch-ready breaks any combinational path from exReady
  assign fetch_ready_d = (state_d != TWO);

  // Saturating stall-cycle counter; deliberately untouched by flush
  always_comb begin
    stall_d = stall_q;
    if (exValid && !exReady && !(&stall_q)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  // State, buffer and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= EMPTY;
      fetch_ready_q <= 1'b1;
      // NOTE: buffer entries are reset because they drive ex* directly and
      // those outputs must read 0 out of reset.
      head_q        <= '0;
      skid_q        <= '0;
      stall_q       <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q       <= state_d;
      fetch_ready_q <= fetch_ready_d;
      head_q        <= head_d;
      skid_q        <= skid_d;
      stall_q       <= stall_d;
    end
  end

  assign fetchReady = fetch_ready_q;
  assign exPc       = head_q.pc;
  assign exInst     = head_q.inst;
  assign exImmType  = head_q.imm_type;
  assign exImm      = head_q.imm;
  assign exRs1      = head_q.rs1;
  assign exRs2      = head_q.rs2;
  assign exRd       = head_q.rd;
  assign exIllegal  = head_q.illegal;
  assign stallCount = stall_q;

endmodule : decode_stage_controller

// File: tb/tb_decode_stage_controller.sv
// Directed testbench for decode_stage_controller.
module tb_decode_stage_controller;

  localparam int XLEN        = 64;
  localparam int STALL_CNT_W = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   fetchValid;
  logic                   fetchReady;
  logic [31:0]            fetchInst;
  logic [XLEN-1:0]        fetchPc;
  logic                   flush;
  logic                   exValid;
  logic                   exReady;
  logic [XLEN-1:0]        exPc;
  logic [31:0]            exInst;
  logic [2:0]             exImmType;
  logic [XLEN-1:0]        exImm;
  logic [4:0]             exRs1;
  logic [4:0]             exRs2;
  logic [4:0]             exRd;
  logic                   exIllegal;
  logic [STALL_CNT_W-1:0] stallCount;

  int n_pass  = 0;
  int n_total = 0;

  decode_stage_controller #(
    .XLEN       (XLEN),
    .STALL_CNT_W(STALL_CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fetchValid(fetchValid),
    .fetchReady(fetchReady),
    .fetchInst (fetchInst),
    .fetchPc   (fetchPc),
    .flush     (flush),
    .exValid   (exValid),
    .exReady   (exReady),
    .exPc      (exPc),
    .exInst    (exInst),
    .exImmType (exImmType),
    .exImm     (exImm),
    .exRs1     (exRs1),
    .exRs2     (exRs2),
    .exRd      (exRd),
    .exIllegal (exIllegal),
    .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetchValid = 1'b0; fetchInst = '0; fetchPc = '0;
    flush = 1'b0; exReady = 1'b0;
    tick(); tick();
    n_total++;
    if ({fetchReady, exValid, exPc, exInst, exImm, stallCount} !==
        {1'b1, 1'b0, 64'h0, 32'h0, 64'h0, 32'h0})
      $display("FAIL reset_state: rdy=%b vld=%b pc=%h inst=%h imm=%h stall=%0d, need rdy=1 vld=0 data=0 stall=0",
               fetchReady, exValid, exPc, exInst, exImm, stallCount);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_addi_lui_beq();
    exReady = 1'b1; fetchValid = 1'b1;
    fetchInst = 32'hFFF00093; fetchPc = 64'h1000;
    tick();
    n_total++;
    if ({exValid, exImmType, exImm, exRd, exRs1, exPc} !==
        {1'b1, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 5'd0, 64'h1000})
      $display("FAIL addi: vld=%b type=%b imm=%h rd=%0d rs1=%0d pc=%h, need 1 000 ffffffffffffffff 1 0 1000",
               exValid, exImmType, exImm, exRd, exRs1, exPc);
    else n_pass++;
    fetchInst = 32'h123452B7; fetchPc = 64'h1004;
    tick();
    n_total++;
    if ({exValid, exImmType, exImm, exRd} !==
        {1'b1, 3'b011, 64'h0000_0000_1234_5000, 5'd5})
      $display("FAIL lui: vld=%b type=%b imm=%h rd=%0d, need 1 011 0000000012345000 5",
               exValid, exImmType, exImm, exRd);
    else n_pass++;
    fetchInst = 32'hFE000EE3; fetchPc = 64'h1008;
    tick();
    n_total++;
    if ({exValid, exImmType, exImm, exPc} !==
        {1'b1, 3'b010, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1008})
      $display("FAIL beq: vld=%b type=%b imm=%h pc=%h, need 1 010 fffffffffffffffc 1008",
               exValid, exImmType, exImm, exPc);
    else n_pass++;
    fetchValid = 1'b0;
    tick();
    n_total++;
    if (exValid !== 1'b0)
      $display("FAIL drain_empty: vld=%b, need 0", exValid);
    else n_pass++;
  endtask

  task automatic test_stall();
    exReady = 1'b0; fetchValid = 1'b1;
    fetchInst = 32'h00100113; fetchPc = 64'h2000;
    tick();
    n_total++;
    if ({exValid, exInst, fetchReady, stallCount} !== {1'b1, 32'h00100113, 1'b1, 32'd0})
      $display("FAIL stall_first: vld=%b inst=%h rdy=%b stall=%0d, need 1 00100113 1 0",
               exValid, exInst, fetchReady, stallCount);
    else n_pass++;
    fetchInst = 32'h00200193; fetchPc = 64'h2004;
    tick();
    n_total++;
    if ({exInst, fetchReady, stallCount} !== {32'h00100113, 1'b0, 32'd1})
      $display("FAIL stall_full: inst=%h rdy=%b stall=%0d, need 00100113 0 1",
               exInst, fetchReady, stallCount);
    else n_pass++;
    fetchInst = 32'h00300213; fetchPc = 64'h2008;
    tick();
    tick();
    n_total++;
    if ({exInst, exPc, fetchReady, stallCount} !== {32'h00100113, 64'h2000, 1'b0, 32'd3})
      $display("FAIL stall_hold: inst=%h pc=%h rdy=%b stall=%0d, need 00100113 2000 0 3",
               exInst, exPc, fetchReady, stallCount);
    else n_pass++;
    exReady = 1'b1;
    tick();
    n_total++;
    if ({exValid, exInst, fetchReady, stallCount} !== {1'b1, 32'h00200193, 1'b1, 32'd3})
      $display("FAIL drain_second: vld=%b inst=%h rdy=%b stall=%0d, need 1 00200193 1 3",
               exValid, exInst, fetchReady, stallCount);
    else n_pass++;
    tick();
    n_total++;
    if ({exValid, exInst, exRd} !== {1'b1, 32'h00300213, 5'd4})
      $display("FAIL drain_third: vld=%b inst=%h rd=%0d, need 1 00300213 4",
               exValid, exInst, exRd);
    else n_pass++;
    fetchValid = 1'b0;
    tick();
    n_total++;
    if (exValid !== 1'b0)
      $display("FAIL drain_done: vld=%b, need 0", exValid);
    else n_pass++;
  endtask

  task automatic test_flush();
    exReady = 1'b0; fetchValid = 1'b1;
    fetchInst = 32'h00500293; tick();
    fetchInst = 32'h00600313; tick();
    fetchInst = 32'h00700393; flush = 1'b1;
    tick();
    n_total++;
    if ({exValid, fetchReady, stallCount} !== {1'b0, 1'b1, 32'd5})
      $display("FAIL flush_two: vld=%b rdy=%b stall=%0d, need 0 1 5",
               exValid, fetchReady, stallCount);
    else n_pass++;
    flush = 1'b0; fetchValid = 1'b0; exReady = 1'b1;
    tick();
    n_total++;
    if ({exValid, fetchReady} !== {1'b0, 1'b1})
      $display("FAIL flush_after: vld=%b rdy=%b, need 0 1", exValid, fetchReady);
    else n_pass++;
    // Flush while one entry is buffered and a new accept is offered
    fetchValid = 1'b1; fetchInst = 32'h00800413;
    tick();
    fetchInst = 32'h00900493; flush = 1'b1;
    tick();
    n_total++;
    if ({exValid, fetchReady, stallCount} !== {1'b0, 1'b1, 32'd5})
      $display("FAIL flush_one: vld=%b rdy=%b stall=%0d, need 0 1 5",
               exValid, fetchReady, stallCount);
    else n_pass++;
    flush = 1'b0; fetchValid = 1'b0;
    tick();
    n_total++;
    if (exValid !== 1'b0 || exInst === 32'h00900493)
      $display("FAIL flush_dropped: vld=%b inst=%h, need vld 0 and inst not 00900493",
               exValid, exInst);
    else n_pass++;
  endtask

  task automatic test_illegal_r();
    exReady = 1'b1; fetchValid = 1'b1; fetchInst = 32'h00000000;
    tick();
    n_total++;
    if ({exValid, exIllegal, exImmType, exImm} !== {1'b1, 1'b1, 3'b111, 64'h0})
      $display("FAIL illegal: vld=%b ill=%b type=%b imm=%h, need 1 1 111 0",
               exValid, exIllegal, exImmType, exImm);
    else n_pass++;
    fetchInst = 32'h002081B3;
    tick();
    n_total++;
    if ({exValid, exIllegal, exImmType, exImm, exRs1, exRs2, exRd} !==
        {1'b1, 1'b0, 3'b111, 64'h0, 5'd1, 5'd2, 5'd3})
      $display("FAIL add_r: vld=%b ill=%b type=%b imm=%h rs1=%0d rs2=%0d rd=%0d, need 1 0 111 0 1 2 3",
               exValid, exIllegal, exImmType, exImm, exRs1, exRs2, exRd);
    else n_pass++;
    fetchValid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    exReady = 1'b0; fetchValid = 1'b1;
    fetchInst = 32'h00A00513; fetchPc = 64'h3000; tick();
    fetchInst = 32'h00B00593; fetchPc = 64'h3004; tick();
    fetchValid = 1'b0;
    n_total++;
    if ({exValid, fetchReady, stallCount} !== {1'b1, 1'b0, 32'd6})
      $display("FAIL pre_reset_two: vld=%b rdy=%b stall=%0d, need 1 0 6",
               exValid, fetchReady, stallCount);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({fetchReady, exValid, exPc, exInst, exImmType, exImm, exIllegal, stallCount} !==
        {1'b1, 1'b0, 64'h0, 32'h0, 3'b000, 64'h0, 1'b0, 32'h0})
      $display("FAIL async_reset: rdy=%b vld=%b pc=%h inst=%h imm=%h stall=%0d, need 1 0 0 0 0 0",
               fetchReady, exValid, exPc, exInst, exImm, stallCount);
    else n_pass++;
    tick();
    rst = 1'b0;
    exReady = 1'b1; fetchValid = 1'b1;
    fetchInst = 32'h00C00613; fetchPc = 64'h4000;
    tick();
    fetchValid = 1'b0;
    n_total++;
    if ({exValid, exInst, exPc, exImm} !== {1'b1, 32'h00C00613, 64'h4000, 64'd12})
      $display("FAIL post_reset_accept: vld=%b inst=%h pc=%h imm=%h, need 1 00c00613 4000 c",
               exValid, exInst, exPc, exImm);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_addi_lui_beq();
    test_stall();
    test_flush();
    test_illegal_r();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_decode_stage_controller
